bus_router: RTL and testbench

Parametrised, registered successor to the CPU datapath bus routing logic. Resolves N source registers onto M internal buses per cycle, using per-bus source enables, open-drain zero masks and a pass link from one designated bus. Models NMOS bus behaviour: precharge to all-ones, a charge-hold window when a bus floats, and selectable priority or wired-AND resolution. Sits between the register file/ALU and the memory address/data latches. Also reports bus contention for verification and debug.

---
 rtl/bus_router_if.sv | 26 ++
 rtl/bus_router.sv | 137 +++++++++++++
 tb/tb_bus_router.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_router_if.sv
// Bus-side bundle for bus_router: source data, per-bus enables, pulldown masks and link enables in;
// registered bus values and status flags out.
interface bus_router_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned NUM_BUS = 4
);
    logic [NUM_SRC*DATA_W-1:0]  i_src_data;
    logic [NUM_BUS*NUM_SRC-1:0] i_src_en;
    logic [NUM_BUS*DATA_W-1:0]  i_zero_mask;
    logic [NUM_BUS-1:0]         i_link_en;
    logic [NUM_BUS*DATA_W-1:0]  o_bus;
    logic [NUM_BUS-1:0]         o_driven;
    logic [NUM_BUS-1:0]         o_contention;
    logic [15:0]                o_contention_count;

    modport master (
        output i_src_data, i_src_en, i_zero_mask, i_link_en,
        input  o_bus, o_driven, o_contention, o_contention_count
    );

    modport slave (
        input  i_src_data, i_src_en, i_zero_mask, i_link_en,
        output o_bus, o_driven, o_contention, o_contention_count
    );
endinterface

// File: rtl/bus_router.sv
// Registered NMOS-style bus router: resolves NUM_SRC sources onto NUM_BUS buses with precharge,
// charge-hold, open-drain zero masks, a pass link from bus LINK_SRC and contention reporting.
module bus_router #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned NUM_BUS     = 4,
    parameter int unsigned LINK_SRC    = 1,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned MODE        = 0
) (
    input logic         i_clk,
    input logic         i_reset,
    bus_router_if.slave bif_io
);

    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    typedef struct packed {
        logic              driven;
        logic              contend;
        logic [DATA_W-1:0] val;
    } res_t;

    // The link occupies the last driver slot, so it loses every priority tie.
    function automatic res_t resolve(input logic [NUM_SRC-1:0]        en,
                                     input logic [NUM_SRC*DATA_W-1:0] data,
                                     input logic                      link_on,
                                     input logic [DATA_W-1:0]         link_val);
        res_t              r;
        logic [NUM_SRC:0]  on_all;
        logic [DATA_W-1:0] val_all [NUM_SRC+1];
        logic [DATA_W-1:0] first;
        logic              have;
        on_all = {link_on, en};
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            val_all[s] = data[s*DATA_W +: DATA_W];
        end
        val_all[NUM_SRC] = link_val;
        r.driven  = 1'b0;
        r.contend = 1'b0;
        r.val     = (MODE == 1) ? '1 : '0;
        first     = '0;
        have      = 1'b0;
        for (int s = 0; s <= int'(NUM_SRC); s++) begin
            if (on_all[s]) begin
                if (!have) begin
                    first = val_all[s];
                    have  = 1'b1;
                    if (MODE == 0) r.val = val_all[s];
                end else if (val_all[s] != first) begin
                    r.contend = 1'b1;
                end
                if (MODE == 1) r.val = r.val & val_all[s];
            end
        end
        r.driven = have;
        return r;
    endfunction

    logic [DATA_W-1:0]  bus_q  [NUM_BUS];
    logic [DATA_W-1:0]  bus_d  [NUM_BUS];
    logic [HW-1:0]      hold_q [NUM_BUS];
    logic [HW-1:0]      hold_d [NUM_BUS];
    logic [NUM_BUS-1:0] driven_q, driven_d;
    logic [NUM_BUS-1:0] cont_q, cont_d;
    logic [15:0]        cnt_q, cnt_d;

    res_t              link_res;
    logic [DATA_W-1:0] link_val;
    res_t              res [NUM_BUS];
    logic [DATA_W-1:0] zm;

    always_comb begin
        link_res = resolve(bif_io.i_src_en[LINK_SRC*NUM_SRC +: NUM_SRC], bif_io.i_src_data,
                           1'b0, '0);
        link_val = link_res.val & ~bif_io.i_zero_mask[LINK_SRC*DATA_W +: DATA_W];
    end

    always_comb begin
        zm       = '0;
        driven_d = '0;
        cont_d   = '0;
        for (int b = 0; b < int'(NUM_BUS); b++) begin
            res[b] = resolve(bif_io.i_src_en[b*NUM_SRC +: NUM_SRC], bif_io.i_src_data,
                             (b != int'(LINK_SRC)) && bif_io.i_link_en[b] && link_res.driven,
                             link_val);
            zm = bif_io.i_zero_mask[b*DATA_W +: DATA_W];
            // Pulldown applies to driven, held and precharged values alike.
            if (res[b].driven) begin
                bus_d[b]  = res[b].val & ~zm;
                hold_d[b] = '0;
            end else if (hold_q[b] < HOLD_MAX) begin
                bus_d[b]  = bus_q[b] & ~zm;
                hold_d[b] = hold_q[b] + HW'(1);
            end else begin
                bus_d[b]  = ~zm;
                hold_d[b] = HOLD_MAX;
            end
            driven_d[b] = res[b].driven;
            cont_d[b]   = res[b].contend;
        end
        cnt_d = ((|cont_d) && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int b = 0; b < int'(NUM_BUS); b++) begin
                bus_q[b]  <= '1;
                hold_q[b] <= HOLD_MAX;
            end
            driven_q <= '0;
            cont_q   <= '0;
            cnt_q    <= '0;
        end else begin
            for (int b = 0; b < int'(NUM_BUS); b++) begin
                bus_q[b]  <= bus_d[b];
                hold_q[b] <= hold_d[b];
            end
            driven_q <= driven_d;
            cont_q   <= cont_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        bif_io.o_bus = '0;
        for (int b = 0; b < int'(NUM_BUS); b++) begin
            bif_io.o_bus[b*DATA_W +: DATA_W] = bus_q[b];
        end
    end

    assign bif_io.o_driven           = driven_q;
    assign bif_io.o_contention       = cont_q;
    assign bif_io.o_contention_count = cnt_q;

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: one priority-mode and one wired-AND instance share stimulus;
// expectations are queued when inputs are driven and checked after the following edge.
module tb_bus_router;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bus_router_if #(.DATA_W(8), .NUM_SRC(8), .NUM_BUS(4)) b0 ();
    bus_router_if #(.DATA_W(8), .NUM_SRC(8), .NUM_BUS(4)) b1 ();

    assign b1.i_src_data  = b0.i_src_data;
    assign b1.i_src_en    = b0.i_src_en;
    assign b1.i_zero_mask = b0.i_zero_mask;
    assign b1.i_link_en   = b0.i_link_en;

    bus_router #(.MODE(0)) dut0 (.i_clk(clk), .i_reset(rst), .bif_io(b0));
    bus_router #(.MODE(1)) dut1 (.i_clk(clk), .i_reset(rst), .bif_io(b1));

    typedef struct {
        string       tag;
        int          dut;
        logic [31:0] bus;
        logic [31:0] care;
        logic [3:0]  drv;
        logic [3:0]  con;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input string tag, input int dut, input logic [31:0] bus,
                            input logic [31:0] care, input logic [3:0] drv,
                            input logic [3:0] con, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag; e.dut = dut; e.bus = bus; e.care = care;
        e.drv = drv; e.con = con; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic verify();
        exp_t        e;
        logic [31:0] ob;
        logic [3:0]  od, oc;
        logic [15:0] on;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                ob = b0.o_bus; od = b0.o_driven; oc = b0.o_contention; on = b0.o_contention_count;
            end else begin
                ob = b1.o_bus; od = b1.o_driven; oc = b1.o_contention; on = b1.o_contention_count;
            end
            tests++;
            assert ((ob & e.care) === (e.bus & e.care)) else begin
                fails++;
                $error("FAIL %s dut%0d bus: observed %h expected %h", e.tag, e.dut,
                       ob & e.care, e.bus & e.care);
            end
            tests++;
            assert (od === e.drv) else begin
                fails++;
                $error("FAIL %s dut%0d driven: observed %b expected %b", e.tag, e.dut, od, e.drv);
            end
            tests++;
            assert (oc === e.con) else begin
                fails++;
                $error("FAIL %s dut%0d contention: observed %b expected %b", e.tag, e.dut, oc,
                       e.con);
            end
            tests++;
            assert (on === e.cnt) else begin
                fails++;
                $error("FAIL %s dut%0d count: observed %h expected %h", e.tag, e.dut, on, e.cnt);
            end
        end
    endtask

    task automatic clear_in();
        rst            = 1'b0;
        b0.i_src_data  = '0;
        b0.i_src_en    = '0;
        b0.i_zero_mask = '0;
        b0.i_link_en   = '0;
    endtask

    task automatic drive_src(input int bus, input int src, input logic [7:0] val);
        b0.i_src_data[src*8 +: 8] = val;
        b0.i_src_en[bus*8 + src]  = 1'b1;
    endtask

    // Bus2 hold-window step: optionally drive src4 onto bus2, check bus2 only.
    task automatic hold_step(input string tag, input bit drive, input logic [7:0] val,
                             input logic [7:0] exp, input logic [15:0] cnt);
        clear_in();
        if (drive) drive_src(2, 4, val);
        push_exp(tag, 0, {8'h00, exp, 16'h0000}, 32'h00FF_0000, drive ? 4'b0100 : 4'b0000,
                 4'b0000, cnt);
        tick();
        verify();
    endtask

    initial begin
        clear_in();
        rst            = 1'b1;
        b0.i_src_data  = {$urandom, $urandom};
        b0.i_src_en    = $urandom;
        b0.i_zero_mask = $urandom;
        b0.i_link_en   = 4'($urandom_range(0, 15));
        push_exp("reset", 0, 32'hFFFF_FFFF, '1, 4'h0, 4'h0, 16'h0);
        push_exp("reset", 1, 32'hFFFF_FFFF, '1, 4'h0, 4'h0, 16'h0);
        tick(); verify();

        clear_in();
        push_exp("idle_precharge", 0, 32'hFFFF_FFFF, '1, 4'h0, 4'h0, 16'h0);
        push_exp("idle_precharge", 1, 32'hFFFF_FFFF, '1, 4'h0, 4'h0, 16'h0);
        tick(); verify();

        clear_in();
        drive_src(0, 0, 8'h12);
        drive_src(0, 3, 8'h34);
        push_exp("prio_contend", 0, 32'hFFFF_FF12, '1, 4'b0001, 4'b0001, 16'd1);
        push_exp("and_contend", 1, 32'hFFFF_FF10, '1, 4'b0001, 4'b0001, 16'd1);
        tick(); verify();

        drive_src(0, 3, 8'h12);
        push_exp("prio_same", 0, 32'hFFFF_FF12, '1, 4'b0001, 4'b0000, 16'd1);
        push_exp("and_same", 1, 32'hFFFF_FF12, '1, 4'b0001, 4'b0000, 16'd1);
        tick(); verify();

        clear_in();
        drive_src(3, 0, 8'hF0);
        drive_src(3, 5, 8'h3C);
        push_exp("prio_bus3", 0, 32'hF0FF_FF12, '1, 4'b1000, 4'b1000, 16'd2);
        push_exp("and_bus3", 1, 32'h30FF_FF12, '1, 4'b1000, 4'b1000, 16'd2);
        tick(); verify();

        clear_in();
        drive_src(1, 2, 8'hA5);
        b0.i_link_en   = 4'b0001;
        b0.i_zero_mask = 32'h0000_0100;
        push_exp("link_mask", 0, 32'hF0FF_A4A4, '1, 4'b0011, 4'b0000, 16'd2);
        push_exp("link_mask", 1, 32'h30FF_A4A4, '1, 4'b0011, 4'b0000, 16'd2);
        tick(); verify();

        clear_in();
        b0.i_link_en = 4'b0001;
        push_exp("link_undriven", 0, 32'hF0FF_A4A4, '1, 4'b0000, 4'b0000, 16'd2);
        tick(); verify();

        hold_step("hold_drive",   1'b1, 8'h55, 8'h55, 16'd2);
        hold_step("hold_1",       1'b0, 8'h00, 8'h55, 16'd2);
        hold_step("hold_2",       1'b0, 8'h00, 8'h55, 16'd2);
        hold_step("hold_decay",   1'b0, 8'h00, 8'hFF, 16'd2);
        hold_step("redrive_a",    1'b1, 8'h55, 8'h55, 16'd2);
        hold_step("redrive_a1",   1'b0, 8'h00, 8'h55, 16'd2);
        hold_step("redrive_b",    1'b1, 8'h66, 8'h66, 16'd2);
        hold_step("redrive_b1",   1'b0, 8'h00, 8'h66, 16'd2);
        hold_step("redrive_b2",   1'b0, 8'h00, 8'h66, 16'd2);
        hold_step("redrive_dcy",  1'b0, 8'h00, 8'hFF, 16'd2);
        hold_step("pre_rst_drv",  1'b1, 8'h77, 8'h77, 16'd2);

        clear_in();
        rst = 1'b1;
        push_exp("rst_in_hold", 0, 32'hFFFF_FFFF, '1, 4'h0, 4'h0, 16'd0);
        tick(); verify();

        hold_step("post_rst",     1'b0, 8'h00, 8'hFF, 16'd0);
        hold_step("mask_drive",   1'b1, 8'h55, 8'h55, 16'd0);

        clear_in();
        b0.i_zero_mask = 32'h000F_0000;
        push_exp("mask_on_hold", 0, 32'h0050_0000, 32'h00FF_0000, 4'h0, 4'h0, 16'd0);
        tick(); verify();

        clear_in();
        drive_src(1, 2, 8'hA5);
        drive_src(0, 6, 8'h0F);
        b0.i_link_en = 4'b0011;
        push_exp("link_prio", 0, 32'h0000_A50F, 32'h0000_FFFF, 4'b0011, 4'b0001, 16'd1);
        push_exp("link_and", 1, 32'h0000_A505, 32'h0000_FFFF, 4'b0011, 4'b0001, 16'd1);
        tick(); verify();

        clear_in();
        drive_src(0, 0, 8'h12);
        drive_src(0, 3, 8'h34);
        repeat (65539) @(posedge clk);
        push_exp("sat_prio", 0, 32'h0000_0012, 32'h0000_00FF, 4'b0001, 4'b0001, 16'hFFFF);
        push_exp("sat_and", 1, 32'h0000_0010, 32'h0000_00FF, 4'b0001, 4'b0001, 16'hFFFF);
        tick(); verify();

        push_exp("sat_hold", 0, 32'h0000_0012, 32'h0000_00FF, 4'b0001, 4'b0001, 16'hFFFF);
        tick(); verify();

        rst = 1'b1;
        push_exp("sat_reset", 0, 32'hFFFF_FFFF, '1, 4'h0, 4'h0, 16'd0);
        push_exp("sat_reset", 1, 32'hFFFF_FFFF, '1, 4'h0, 4'h0, 16'd0);
        tick(); verify();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
